// File: rtl/simon_pkt_arbiter.sv
// Round-robin arbiter sharing one SIMON packet engine between two requesters.
// Byte 0 (info) is pkt[7:0]; bit 0 set marks a key packet. Optional key-ownership check: SIMON_ARB_KEYLOCK_EN.
module simon_pkt_arbiter #(
    parameter int PKT_BYTES = 18,
    parameter int TIMEOUT   = 255
) (
    input  logic                   clk,
    input  logic                   R,
    input  logic [1:0]             req,
    input  logic [PKT_BYTES*8-1:0] req_pkt0,
    input  logic [PKT_BYTES*8-1:0] req_pkt1,
    output logic [1:0]             gnt,
    output logic [1:0]             ack,
    output logic [1:0]             err,
    output logic [1:0]             rsp_valid,
    input  logic [1:0]             rsp_read,
    output logic [PKT_BYTES*8-1:0] rsp_pkt,
    output logic                   eng_newPKT,
    output logic [PKT_BYTES*8-1:0] eng_in,
    input  logic                   eng_loadPKT,
    input  logic                   eng_donePKT,
    input  logic                   eng_outdone,
    output logic                   eng_readPKT,
    input  logic [PKT_BYTES*8-1:0] eng_out
);

    localparam int PW  = PKT_BYTES * 8;
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_LOAD, S_WAIT_OUT, S_DELIVER, S_REJECT
    } state_t;

    state_t         state_q, state_d;
    logic           ptr_q, ptr_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic [1:0]     gnt_q, gnt_d;
    logic [1:0]     ack_q, ack_d;
    logic [1:0]     err_q, err_d;
    logic [1:0]     rspv_q, rspv_d;
    logic [PW-1:0]  rsp_pkt_q, rsp_pkt_d;
    logic           newpkt_q, newpkt_d;
    logic           readpkt_q, readpkt_d;

    logic [1:0]     req_m;
    logic           pick;
    logic           load_exit, wd_tick, done_ok, fail;

`ifdef SIMON_ARB_KEYLOCK_EN
    logic [1:0]     key_owner_q, key_owner_d;
    logic           pick_is_key;
`endif

    assign eng_in = gnt_q[1] ? req_pkt1 : (gnt_q[0] ? req_pkt0 : '0);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wd_d      = '0;
        gnt_d     = gnt_q;
        ack_d     = 2'b00;
        err_d     = 2'b00;
        rspv_d    = rspv_q;
        rsp_pkt_d = rsp_pkt_q;
        readpkt_d = 1'b0;
        load_exit = 1'b0;
        wd_tick   = 1'b0;
        done_ok   = 1'b0;
        fail      = 1'b0;
        // A requester still showing its ack/err pulse has not had a chance to drop req yet.
        req_m     = req & ~(ack_q | err_q);
        pick      = (req_m == 2'b11) ? ptr_q : req_m[1];
`ifdef SIMON_ARB_KEYLOCK_EN
        key_owner_d = key_owner_q;
        pick_is_key = pick ? req_pkt1[0] : req_pkt0[0];
`endif

        case (state_q)
            S_IDLE: begin
                if (|req_m) begin
                    gnt_d   = pick ? 2'b10 : 2'b01;
                    state_d = S_ISSUE;
`ifdef SIMON_ARB_KEYLOCK_EN
                    if (!pick_is_key && (key_owner_q != gnt_d))
                        state_d = S_REJECT;
`endif
                end
            end
            S_ISSUE: begin
                if (eng_loadPKT) begin
                    if (eng_donePKT) load_exit = 1'b1;
                    else             state_d   = S_LOAD;
                end else begin
                    wd_tick = 1'b1;
                end
            end
            S_LOAD: begin
                if (eng_donePKT) load_exit = 1'b1;
                else             wd_tick   = 1'b1;
            end
            S_WAIT_OUT: begin
                if (eng_outdone) begin
                    rsp_pkt_d = eng_out;
                    readpkt_d = 1'b1;
                    rspv_d    = gnt_q;
                    state_d   = S_DELIVER;
                end else begin
                    wd_tick = 1'b1;
                end
            end
            S_DELIVER: begin
                if (|(rsp_read & gnt_q)) begin
                    rspv_d  = 2'b00;
                    done_ok = 1'b1;
                end
            end
            S_REJECT: fail = 1'b1;
            default:  state_d = S_IDLE;
        endcase

        if (load_exit) begin
            if (eng_in[0]) begin
                done_ok = 1'b1;
`ifdef SIMON_ARB_KEYLOCK_EN
                key_owner_d = gnt_q;
`endif
            end else begin
                state_d = S_WAIT_OUT;
            end
        end

        if (wd_tick) begin
            if (wd_q == WDW'(TIMEOUT - 1)) fail = 1'b1;
            else                           wd_d = wd_q + 1'b1;
        end

        if (done_ok) ack_d = gnt_q;
        if (fail)    err_d = gnt_q;
        if (done_ok || fail) begin
            gnt_d   = 2'b00;
            state_d = S_IDLE;
            ptr_d   = ~gnt_q[1];
        end

        // Registered so newPKT rises on the second ISSUE cycle and drops the cycle after load/abort.
        newpkt_d = (state_q == S_ISSUE) && (state_d == S_ISSUE);
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state_q   <= S_IDLE;
            ptr_q     <= 1'b0;
            wd_q      <= '0;
            gnt_q     <= 2'b00;
            ack_q     <= 2'b00;
            err_q     <= 2'b00;
            rspv_q    <= 2'b00;
            rsp_pkt_q <= '0;
            newpkt_q  <= 1'b0;
            readpkt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wd_q      <= wd_d;
            gnt_q     <= gnt_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rspv_q    <= rspv_d;
            rsp_pkt_q <= rsp_pkt_d;
            newpkt_q  <= newpkt_d;
            readpkt_q <= readpkt_d;
        end
    end

`ifdef SIMON_ARB_KEYLOCK_EN
    always_ff @(posedge clk or posedge R) begin
        if (R) key_owner_q <= 2'b00;
        else   key_owner_q <= key_owner_d;
    end
`endif

    assign gnt         = gnt_q;
    assign ack         = ack_q;
    assign err         = err_q;
    assign rsp_valid   = rspv_q;
    assign rsp_pkt     = rsp_pkt_q;
    assign eng_newPKT  = newpkt_q;
    assign eng_readPKT = readpkt_q;

    // A granted requester must hold req until it sees ack or err.
    a_req0_held: assert property (@(posedge clk) disable iff (R) gnt_q[0] |-> req[0]);
    a_req1_held: assert property (@(posedge clk) disable iff (R) gnt_q[1] |-> req[1]);

endmodule

// File: tb/tb_simon_pkt_arbiter.sv
// Bench for simon_pkt_arbiter: vector table of transactions plus hand-written corner sequences.
module tb_simon_pkt_arbiter;

    localparam int PKT_BYTES = 18;
    localparam int PW        = PKT_BYTES * 8;
    localparam int TIMEOUT   = 255;

    logic          clk = 1'b0;
    logic          R;
    logic [1:0]    req, rsp_read;
    logic [PW-1:0] req_pkt0, req_pkt1, eng_out;
    logic          eng_loadPKT, eng_donePKT, eng_outdone;
    logic [1:0]    gnt, ack, err, rsp_valid;
    logic [PW-1:0] rsp_pkt, eng_in;
    logic          eng_newPKT, eng_readPKT;

    simon_pkt_arbiter #(.PKT_BYTES(PKT_BYTES), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .R(R), .req(req), .req_pkt0(req_pkt0), .req_pkt1(req_pkt1),
        .gnt(gnt), .ack(ack), .err(err), .rsp_valid(rsp_valid), .rsp_read(rsp_read),
        .rsp_pkt(rsp_pkt), .eng_newPKT(eng_newPKT), .eng_in(eng_in),
        .eng_loadPKT(eng_loadPKT), .eng_donePKT(eng_donePKT), .eng_outdone(eng_outdone),
        .eng_readPKT(eng_readPKT), .eng_out(eng_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            who;
        logic [7:0]    info;
        logic [PW-1:0] body;
        logic [PW-1:0] eng_res;
        int            out_dly;
        bit            same_cyc;
        bit            exp_key;
        logic [PW-1:0] exp_rsp;
    } vec_t;

    typedef struct {
        bit            who;
        logic [PW-1:0] rsp;
    } sb_t;

    sb_t  sbq[$];
    vec_t vecs[7];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chkw(input string nm, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic chk2(input string nm, input logic [1:0] got, input logic [1:0] exp);
        chkw(nm, PW'(got), PW'(exp));
    endtask

    task automatic chk1(input string nm, input logic got, input logic exp);
        chkw(nm, PW'(got), PW'(exp));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] oh(input bit w);
        return w ? 2'b10 : 2'b01;
    endfunction

    task automatic drive_req(input bit who, input logic [PW-1:0] pkt);
        if (who) req_pkt1 = pkt;
        else     req_pkt0 = pkt;
        req[who] = 1'b1;
    endtask

    task automatic wait_newpkt(input string nm);
        int n = 0;
        while (!eng_newPKT && n < 20) begin
            tick;
            n++;
        end
        chk1(nm, eng_newPKT, 1'b1);
    endtask

    task automatic pop_rsp(input string nm);
        sb_t e;
        if (sbq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: response seen, scoreboard empty", nm);
        end else begin
            e = sbq.pop_front();
            chk2({nm, "_owner"}, rsp_valid, oh(e.who));
            chkw({nm, "_pkt"}, rsp_pkt, e.rsp);
        end
    endtask

    // Engine side of a key packet: load, then done; ack must follow the done cycle.
    task automatic eng_key(input bit who);
        wait_newpkt("key_newpkt");
        eng_loadPKT = 1'b1;
        tick;
        eng_loadPKT = 1'b0;
        eng_donePKT = 1'b1;
        tick;
        eng_donePKT = 1'b0;
        chk2("key_ack", ack, oh(who));
        req[who] = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [PW-1:0] pkt;
        pkt = {v.body[PW-1:8], v.info};
        drive_req(v.who, pkt);
        if (!v.exp_key) sbq.push_back('{who: v.who, rsp: v.exp_rsp});
        tick;
        chk2("vec_grant", gnt, oh(v.who));
        chk1("vec_newpkt_early", eng_newPKT, 1'b0);
        tick;
        chk1("vec_newpkt_lat2", eng_newPKT, 1'b1);
        chkw("vec_eng_in", eng_in, pkt);
        eng_loadPKT = 1'b1;
        eng_donePKT = v.same_cyc;
        tick;
        eng_loadPKT = 1'b0;
        chk1("vec_newpkt_drop", eng_newPKT, 1'b0);
        if (!v.same_cyc) begin
            eng_donePKT = 1'b1;
            tick;
        end
        eng_donePKT = 1'b0;
        if (v.exp_key) begin
            chk2("vec_key_ack", ack, oh(v.who));
            chk2("vec_key_no_rsp", rsp_valid, 2'b00);
            chk2("vec_key_gnt_clr", gnt, 2'b00);
            req[v.who] = 1'b0;
        end else begin
            chk2("vec_data_no_early_ack", ack, 2'b00);
            repeat (v.out_dly) tick;
            eng_out     = v.eng_res;
            eng_outdone = 1'b1;
            tick;
            eng_outdone = 1'b0;
            chk1("vec_readpkt", eng_readPKT, 1'b1);
            pop_rsp("vec_rsp");
            rsp_read[v.who] = 1'b1;
            tick;
            rsp_read = 2'b00;
            chk1("vec_readpkt_1cyc", eng_readPKT, 1'b0);
            chk2("vec_data_ack", ack, oh(v.who));
            chk2("vec_rsp_clr", rsp_valid, 2'b00);
            req[v.who] = 1'b0;
        end
        tick;
        chk2("vec_ack_pulse", ack, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [PW-1:0] kp, dp;
        vec_t v;
        int cnt;

        vecs[0] = '{1'b0, 8'h01, {18{8'h11}}, {PW{1'b0}},       0, 1'b0, 1'b1, {PW{1'b0}}};
        vecs[1] = '{1'b0, 8'h00, {18{8'h22}}, {9{16'hBEEF}},    0, 1'b0, 1'b0, {9{16'hBEEF}}};
        vecs[2] = '{1'b1, 8'h01, {18{8'h33}}, {PW{1'b0}},       0, 1'b1, 1'b1, {PW{1'b0}}};
        vecs[3] = '{1'b1, 8'h00, {18{8'h44}}, {18{8'hC3}},      3, 1'b0, 1'b0, {18{8'hC3}}};
        vecs[4] = '{1'b1, 8'h80, {18{8'h55}}, {4{36'h987654321}}, 0, 1'b1, 1'b0, {4{36'h987654321}}};
        vecs[5] = '{1'b0, 8'hFF, {18{8'h66}}, {PW{1'b0}},       0, 1'b0, 1'b1, {PW{1'b0}}};
        vecs[6] = '{1'b0, 8'h02, {18{8'h77}}, {18{8'h5A}},      1, 1'b0, 1'b0, {18{8'h5A}}};

        R = 1'b0; req = 2'b00; rsp_read = 2'b00;
        req_pkt0 = '0; req_pkt1 = '0; eng_out = '0;
        eng_loadPKT = 1'b0; eng_donePKT = 1'b0; eng_outdone = 1'b0;
        #2 R = 1'b1;
        #3;
        chk2("rst_gnt", gnt, 2'b00);
        chk2("rst_ack", ack, 2'b00);
        chk2("rst_err", err, 2'b00);
        chk2("rst_rspv", rsp_valid, 2'b00);
        chk1("rst_newpkt", eng_newPKT, 1'b0);
        chk1("rst_readpkt", eng_readPKT, 1'b0);
        chkw("rst_rsp_pkt", rsp_pkt, {PW{1'b0}});
        chkw("rst_eng_in", eng_in, {PW{1'b0}});

        // Both requesters waiting at reset release.
        kp = {{17{8'h70}}, 8'h01};
        req_pkt0 = kp; req_pkt1 = kp; req = 2'b11;
        tick; tick;
        R = 1'b0;
        tick;
        chk2("contend_first_req0", gnt, 2'b01);
        eng_key(1'b0);
        tick;
        chk2("contend_req1_after_ack0", gnt, 2'b10);
        eng_key(1'b1);
        tick;
        req = 2'b11;
        tick;
        chk2("contend_again_req0", gnt, 2'b01);
        eng_key(1'b0);
        tick;
        chk2("contend_again_req1", gnt, 2'b10);
        eng_key(1'b1);
        tick;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Key back to req0 so its data is acceptable, then an engine that never loads.
        run_vec(vecs[0]);
        drive_req(1'b0, {{17{8'h7E}}, 8'h00});
        tick;
        chk2("to_grant", gnt, 2'b01);
        req_pkt1 = kp;
        req[1] = 1'b1;
        cnt = 1;
        tick;
        while (err == 2'b00 && cnt < 400) begin
            cnt++;
            tick;
        end
        chkw("to_issue_cycles", PW'(cnt), PW'(TIMEOUT));
        chk2("to_err", err, 2'b01);
        chk1("to_newpkt_low", eng_newPKT, 1'b0);
        chk2("to_gnt_clr", gnt, 2'b00);
        req[0] = 1'b0;
        tick;
        chk2("to_then_req1", gnt, 2'b10);
        eng_key(1'b1);
        tick;

        // Non-owner rsp_read must be ignored.
        run_vec(vecs[0]);
        dp = {{17{8'h19}}, 8'h00};
        drive_req(1'b0, dp);
        sbq.push_back('{who: 1'b0, rsp: {18{8'hE7}}});
        tick;
        wait_newpkt("mis_newpkt");
        eng_loadPKT = 1'b1;
        tick;
        eng_loadPKT = 1'b0;
        eng_donePKT = 1'b1;
        tick;
        eng_donePKT = 1'b0;
        eng_out = {18{8'hE7}};
        eng_outdone = 1'b1;
        tick;
        eng_outdone = 1'b0;
        pop_rsp("mis_rsp");
        rsp_read = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk2("mis_rspv_held", rsp_valid, 2'b01);
            chk2("mis_no_ack", ack, 2'b00);
        end
        chkw("mis_rsp_pkt_held", rsp_pkt, {18{8'hE7}});
        rsp_read = 2'b01;
        tick;
        rsp_read = 2'b00;
        chk2("mis_ack", ack, 2'b01);
        req[0] = 1'b0;
        tick;

        // Reset while waiting for the engine's output.
        drive_req(1'b0, dp);
        tick;
        wait_newpkt("rw_newpkt");
        eng_loadPKT = 1'b1;
        tick;
        eng_loadPKT = 1'b0;
        eng_donePKT = 1'b1;
        tick;
        eng_donePKT = 1'b0;
        chk2("rw_no_ack", ack, 2'b00);
        R = 1'b1;
        #1;
        chk2("rw_gnt", gnt, 2'b00);
        chk2("rw_ack", ack, 2'b00);
        chk2("rw_err", err, 2'b00);
        chk2("rw_rspv", rsp_valid, 2'b00);
        chk1("rw_newpkt", eng_newPKT, 1'b0);
        chk1("rw_readpkt", eng_readPKT, 1'b0);
        chkw("rw_rsp_pkt", rsp_pkt, {PW{1'b0}});
        req = 2'b00;
        tick;
        req_pkt0 = kp; req_pkt1 = kp; req = 2'b11;
        tick;
        R = 1'b0;
        tick;
        chk2("rw_ptr_req0_first", gnt, 2'b01);
        eng_key(1'b0);
        tick;
        chk2("rw_then_req1", gnt, 2'b10);
        eng_key(1'b1);
        tick;

`ifdef SIMON_ARB_KEYLOCK_EN
        run_vec(vecs[0]);
        drive_req(1'b1, {{17{8'h42}}, 8'h00});
        tick;
        chk2("kl_grant", gnt, 2'b10);
        chk1("kl_newpkt0", eng_newPKT, 1'b0);
        tick;
        chk2("kl_err", err, 2'b10);
        chk2("kl_gnt_clr", gnt, 2'b00);
        chk1("kl_newpkt1", eng_newPKT, 1'b0);
        req[1] = 1'b0;
        tick;
        chk1("kl_newpkt2", eng_newPKT, 1'b0);
        run_vec(vecs[1]);
`endif

        if (sbq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_leftover: %0d responses never seen", sbq.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/simon_pkt_arbiter.md
Name: simon_pkt_arbiter

Overview:
- Two-requester round-robin arbiter/sequencer sharing one SIMON packet engine (packet-in/packet-out SIMON top level) between two host-side packet sources.
- Grants one requester at a time and drives the engine's new/load/done input handshake.
- For data packets, captures the engine's result packet into a response register, frees the engine, and returns the result to the requester that issued the packet.
- Key packets produce no response.

Parameters:
- PKT_BYTES, 18, packet length in bytes (2 + N/2 for N=32). Byte 0 is the info byte.
- TIMEOUT, 255, maximum cycles spent waiting on any single engine handshake step before aborting.

Ports:
- clk  in  1  single clock, all state on rising edge
- R  in  1  reset, asynchronous, active-high
- req  in  2  per-requester request level; held until ack or err
- req_pkt0  in  PKT_BYTES×8  requester 0 packet; stable while req[0] high
- req_pkt1  in  PKT_BYTES×8  requester 1 packet; stable while req[1] high
- gnt  out  2  one-hot grant, registered
- ack  out  2  1-cycle pulse: engine consumed the granted packet (key) or result delivered (data)
- err  out  2  1-cycle pulse: timeout abort (or key-lock reject)
- rsp_valid  out  2  result available to owner, one-hot
- rsp_read  in  2  owner consumes result while rsp_valid
- rsp_pkt  out  PKT_BYTES×8  registered result packet
- eng_newPKT  out  1  to engine in_newPKT
- eng_in  out  PKT_BYTES×8  to engine in; muxed from granted requester, zero when no grant
- eng_loadPKT  in  1  from engine in_loadPKT
- eng_donePKT  in  1  from engine in_donePKT
- eng_outdone  in  1  from engine out_donePKT
- eng_readPKT  out  1  to engine out_readPKT
- eng_out  in  PKT_BYTES×8  from engine out

Behaviour:
- Reset (async, R=1):
  - state IDLE, priority pointer = 0, watchdog = 0.
  - gnt, ack, err, rsp_valid, eng_newPKT and eng_readPKT are 0; rsp_pkt = 0.
  - Reset mid-packet abandons the transaction with no ack or err.
- Packet type: info byte bit 0: 1 = key packet, 0 = data packet.
- IDLE:
  - If any req is high, grant one: if both are high, grant the requester named by the pointer.
  - gnt is set next cycle; go to ISSUE.
- ISSUE:
  - eng_newPKT = 1.
  - On eng_loadPKT = 1, drop eng_newPKT next cycle; go to LOAD.
- LOAD:
  - On eng_donePKT = 1:
    - key packet: pulse ack[g], clear gnt, go to IDLE.
    - data packet: go to WAIT_OUT.
- WAIT_OUT:
  - On eng_outdone = 1, register eng_out into rsp_pkt.
  - Pulse eng_readPKT for 1 cycle; set rsp_valid[g] next cycle; go to DELIVER.
- DELIVER:
  - Hold rsp_valid[g] and rsp_pkt.
  - On rsp_read[g] = 1: clear rsp_valid, pulse ack[g], clear gnt, go to IDLE.
  - rsp_read on the non-owner bit is ignored.
  - No timeout in DELIVER.
- Priority pointer:
  - Set to the non-served requester on every ack or err.
  - A lone requester is served back-to-back.
- Idle-to-engine latency:
  - req high in IDLE gives eng_newPKT high 2 cycles later (grant cycle, then ISSUE).
  - Minimum data turnaround: eng_outdone gives rsp_valid +1 cycle.
- Watchdog:
  - Counts cycles in ISSUE, LOAD and WAIT_OUT; cleared on every state change.
  - On reaching TIMEOUT: pulse err[g], deassert eng_newPKT, clear gnt, go to IDLE. The engine is not reset.
- Simultaneous events:
  - req arriving for the other requester during a transaction waits.
  - eng_loadPKT and eng_donePKT high in the same cycle in ISSUE: go directly to LOAD's exit action.
- Requester protocol violation: req dropping before ack/err is undefined. An assertion flags it in simulation.
- eng_in is combinationally muxed from the registered gnt.

Optional Feature:
- Macro: SIMON_ARB_KEYLOCK_EN
- Defined:
  - A 2-bit key_owner register (reset 00) is set to one-hot g when a key packet is acked.
  - A data request from a requester that is not key_owner (including the key_owner=00 case) is rejected from IDLE: err pulse 1 cycle after grant, no engine activity, pointer rotates.
  - Key packets are always accepted.
- Undefined: no ownership tracking; any requester may send data under whatever key is loaded.

Test Plan:
- Key then data from req0 (info 0x01, then 0x00):
  - Key packet: eng_newPKT 2 cycles after req, ack[0] the cycle after eng_donePKT, no rsp_valid.
  - Data packet: rsp_pkt equals eng_out, eng_readPKT pulsed once, ack[0] on rsp_read[0].
- Both req high at reset release: req0 served first; req1 granted in the IDLE cycle after ack[0]; a further two-way contention serves req0 again.
- Engine never raises eng_loadPKT: err[0] after 255 ISSUE cycles, eng_newPKT low, req1 then granted normally.
- rsp_read[1] asserted while rsp_valid[0]: ignored, rsp_valid[0] held; rsp_read[0] completes the transaction.
- R asserted in WAIT_OUT: all outputs 0 immediately; after release, the pointer serves req0 first.
- KEYLOCK_EN: req1 sends data after req0 loaded the key: err[1], eng_newPKT never asserted; req0 data completes normally.
